// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the two-master data memory arbiter.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   function automatic int bc_width(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Burst counter: synchronous clear, saturating increment, terminal count at MAX_BURST-1.
module arb_burst_counter
   import data_mem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int W = bc_width(MAX_BURST);
   localparam logic [W-1:0] LAST = W'(MAX_BURST - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         count <= '0;
      end else if (inc && !tc) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between core (m0) and loader/debug (m1).
// Defining ADDR_CHECK_EN adds an out-of-range check that blocks writes, zeroes reads and raises mx_err.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int WL        = 32,
   parameter int DEPTH     = WL * 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [WL-1:0] m0_addr,
   input  logic [WL-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic [WL-1:0] m0_rdata,
   output logic          m0_valid,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [WL-1:0] m1_addr,
   input  logic [WL-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic [WL-1:0] m1_rdata,
   output logic          m1_valid,
   output logic          m1_err,
   output logic          mem_we,
   output logic [WL-1:0] mem_addr,
   output logic [WL-1:0] mem_wd,
   input  logic [WL-1:0] mem_rd
);
   arb_state_t state, state_nxt;
   logic       lp, lp_nxt;
   logic       bc_clr, bc_inc, bc_tc;
   logic       acc0, acc1, acc_we, acc_ok;

   assign acc0 = (state == OWN0) & m0_req;
   assign acc1 = (state == OWN1) & m1_req;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         lp    <= M1;
      end else begin
         state <= state_nxt;
         lp    <= lp_nxt;
      end
   end

   // An owner that drops req hands over immediately; it keeps the bus past the
   // burst limit only while the other master is silent.
   always_comb begin
      state_nxt = state;
      lp_nxt    = lp;
      bc_clr    = 1'b1;
      bc_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) state_nxt = (lp == M1) ? OWN0 : OWN1;
            else if (m0_req)      state_nxt = OWN0;
            else if (m1_req)      state_nxt = OWN1;
         end
         OWN0: begin
            if (!m0_req) begin
               lp_nxt    = M0;
               state_nxt = m1_req ? OWN1 : IDLE;
            end else if (m1_req && bc_tc) begin
               lp_nxt    = M0;
               state_nxt = OWN1;
            end else begin
               bc_clr = 1'b0;
               bc_inc = 1'b1;
            end
         end
         OWN1: begin
            if (!m1_req) begin
               lp_nxt    = M1;
               state_nxt = m0_req ? OWN0 : IDLE;
            end else if (m0_req && bc_tc) begin
               lp_nxt    = M1;
               state_nxt = OWN0;
            end else begin
               bc_clr = 1'b0;
               bc_inc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m0_gnt   = (state == OWN0);
      m1_gnt   = (state == OWN1);
      mem_addr = '0;
      mem_wd   = '0;
      acc_we   = 1'b0;
      if (state == OWN0) begin
         mem_addr = m0_addr;
         mem_wd   = m0_wdata;
         acc_we   = acc0 & m0_we;
      end else if (state == OWN1) begin
         mem_addr = m1_addr;
         mem_wd   = m1_wdata;
         acc_we   = acc1 & m1_we;
      end
   end

   // Gated by reset so a burst cut short by reset cannot land a write on that edge.
   assign mem_we = RST & acc_we & acc_ok;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_bc (
      .clk (CLK),
      .rst (RST),
      .clr (bc_clr),
      .inc (bc_inc),
      .tc  (bc_tc)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         m0_rdata <= '0;
         m0_valid <= 1'b0;
         m1_rdata <= '0;
         m1_valid <= 1'b0;
      end else begin
         m0_valid <= acc0 & ~m0_we;
         m1_valid <= acc1 & ~m1_we;
         if (acc0 && !m0_we) m0_rdata <= acc_ok ? mem_rd : '0;
         if (acc1 && !m1_we) m1_rdata <= acc_ok ? mem_rd : '0;
      end
   end

`ifdef ADDR_CHECK_EN
   assign acc_ok = (mem_addr < WL'(DEPTH));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         m0_err <= 1'b0;
         m1_err <= 1'b0;
      end else begin
         m0_err <= acc0 & ~acc_ok;
         m1_err <= acc1 & ~acc_ok;
      end
   end
`else
   assign acc_ok = 1'b1;
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;

   // DEPTH only matters to the range check; this keeps it referenced without one.
   if (DEPTH > 0) begin : g_depth_unchecked
   end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a transaction-level reference model.
module tb_data_mem_arbiter;
   localparam int WL        = 32;
   localparam int DEPTH     = 256;
   localparam int MAX_BURST = 4;
   localparam int AW        = $clog2(DEPTH);

   logic          CLK, RST;
   logic          m0_req, m0_we, m0_gnt, m0_valid, m0_err;
   logic [WL-1:0] m0_addr, m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_gnt, m1_valid, m1_err;
   logic [WL-1:0] m1_addr, m1_wdata, m1_rdata;
   logic          mem_we;
   logic [WL-1:0] mem_addr, mem_wd, mem_rd;

   data_mem_arbiter #(.WL(WL), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .CLK(CLK), .RST(RST),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_valid(m0_valid), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_valid(m1_valid), .m1_err(m1_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // The memory itself: synchronous write, combinational read, poison outside the array.
   logic [WL-1:0] ram [DEPTH];
   assign mem_rd = (mem_addr < DEPTH) ? ram[mem_addr[AW-1:0]] : 32'hDEAD_BEEF;
   always @(posedge CLK)
      if (mem_we && mem_addr < DEPTH) ram[mem_addr[AW-1:0]] <= mem_wd;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus for the current cycle.
   bit            r_in;
   bit            q[2], w[2];
   logic [WL-1:0] a[2], d[2];

   // Reference model: owner (-1 none), last owner, accesses in current tenure.
   int            own, lp, cnt;
   logic [WL-1:0] exp_mem [DEPTH];
   bit            ev[2], ee[2];
   logic [WL-1:0] erd[2];
   int            last_acc;

   bit  chk_en;
   int  hist[$];
   int  n_acc[2], n_val[2], n_err[2];

   function automatic bit in_rng(input logic [WL-1:0] ad);
`ifdef ADDR_CHECK_EN
      return ad < DEPTH;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      own = -1;
      lp  = 1;
      cnt = 0;
      for (int m = 0; m < 2; m++) begin
         ev[m]  = 1'b0;
         ee[m]  = 1'b0;
         erd[m] = '0;
      end
   endtask

   task automatic cycle();
      int            acc;
      logic [WL-1:0] res;
      bit            other;
      RST      = r_in;
      m0_req   = q[0]; m0_we = w[0]; m0_addr = a[0]; m0_wdata = d[0];
      m1_req   = q[1]; m1_we = w[1]; m1_addr = a[1]; m1_wdata = d[1];
      #1;
      hist.push_back(m0_gnt ? 0 : (m1_gnt ? 1 : -1));
      if (m0_gnt && q[0]) n_acc[0]++;
      if (m1_gnt && q[1]) n_acc[1]++;
      if (m0_valid) n_val[0]++;
      if (m1_valid) n_val[1]++;
      if (m0_err) n_err[0]++;
      if (m1_err) n_err[1]++;

      acc = -1;
      if (own == 0 && q[0]) acc = 0;
      else if (own == 1 && q[1]) acc = 1;

      if (chk_en) begin
         chk("m0_gnt", m0_gnt, own == 0);
         chk("m1_gnt", m1_gnt, own == 1);
         chk("mem_we", mem_we, r_in && acc >= 0 && w[acc] && in_rng(a[acc]));
         if (acc >= 0) begin
            chk("mem_addr", mem_addr, a[acc]);
            if (w[acc]) chk("mem_wd", mem_wd, d[acc]);
         end else if (own < 0) begin
            chk("idle_addr", mem_addr, '0);
            chk("idle_wd", mem_wd, '0);
         end
         chk("m0_valid", m0_valid, ev[0]);
         chk("m1_valid", m1_valid, ev[1]);
         chk("m0_rdata", m0_rdata, erd[0]);
         chk("m1_rdata", m1_rdata, erd[1]);
         chk("m0_err", m0_err, ee[0]);
         chk("m1_err", m1_err, ee[1]);
      end

      last_acc = r_in ? acc : -1;
      if (!r_in) begin
         model_reset();
      end else begin
         ev[0] = 1'b0; ev[1] = 1'b0; ee[0] = 1'b0; ee[1] = 1'b0;
         if (acc >= 0) begin
            res = in_rng(a[acc]) ? exp_mem[a[acc][AW-1:0]] : '0;
            if (!w[acc]) begin
               ev[acc]  = 1'b1;
               erd[acc] = res;
            end else if (in_rng(a[acc])) begin
               exp_mem[a[acc][AW-1:0]] = d[acc];
            end
            ee[acc] = !in_rng(a[acc]);
         end
         if (own < 0) begin
            if (q[0] && q[1]) own = (lp == 0) ? 1 : 0;
            else if (q[0])    own = 0;
            else if (q[1])    own = 1;
            cnt = 0;
         end else begin
            other = q[1-own];
            if (q[own]) begin
               cnt = (cnt + 1 > MAX_BURST) ? MAX_BURST : cnt + 1;
               if (other && cnt >= MAX_BURST) begin
                  lp  = own;
                  own = 1 - own;
                  cnt = 0;
               end
            end else begin
               lp  = own;
               own = other ? 1 - own : -1;
               cnt = 0;
            end
         end
      end
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      for (int m = 0; m < 2; m++) begin
         q[m] = 1'b0; w[m] = 1'b0; a[m] = '0; d[m] = '0;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      r_in = 1'b0;
      cycle();
      cycle();
      r_in = 1'b1;
      hist.delete();
      for (int m = 0; m < 2; m++) begin
         n_acc[m] = 0; n_val[m] = 0; n_err[m] = 0;
      end
   endtask

   task automatic set_req(input int m, input bit rq, input bit we,
                          input logic [WL-1:0] ad, input logic [WL-1:0] wd);
      q[m] = rq; w[m] = we; a[m] = ad; d[m] = wd;
   endtask

   function automatic logic [WL-1:0] rand_addr();
`ifdef ADDR_CHECK_EN
      if ($urandom_range(0, 7) == 0) return WL'(DEPTH + $urandom_range(0, 3));
`endif
      return WL'($urandom_range(0, 15));
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     <= '0;
         exp_mem[i] = '0;
      end
      model_reset();
      last_acc = -1;
      chk_en   = 1'b0;
      idle_inputs();
      r_in = 1'b0;
      #2;
      cycle();
      chk_en = 1'b1;

      // Write then read back through master 0.
      do_reset();
      set_req(0, 1, 1, 5, 32'hA5);
      cycle();
      cycle();
      set_req(0, 1, 0, 5, 0);
      cycle();
      set_req(0, 0, 0, 0, 0);
      cycle();
      chk("t1_gnt_cycle1", hist[1], 0);
      chk("t1_rdata_hold", m0_rdata, 32'hA5);

      // Both request from IDLE: m0 first, four each, then back to m0.
      do_reset();
      set_req(0, 1, 0, 10, 0);
      set_req(1, 1, 0, 11, 0);
      repeat (12) cycle();
      idle_inputs();
      repeat (2) cycle();
      for (int i = 1; i <= 9; i++)
         chk("t2_owner", hist[i], (i <= 4 || i == 9) ? 0 : 1);

      // Only m1 requests: no switch, one result per access.
      do_reset();
      set_req(1, 1, 0, 3, 0);
      repeat (11) cycle();
      idle_inputs();
      repeat (2) cycle();
      chk("t3_m1_accesses", n_acc[1], 10);
      chk("t3_m1_valids", n_val[1], 10);
      chk("t3_m0_accesses", n_acc[0], 0);

      // m0 releases after two accesses while m1 waits.
      do_reset();
      set_req(0, 1, 0, 1, 0);
      cycle();
      set_req(1, 1, 0, 2, 0);
      repeat (2) cycle();
      set_req(0, 0, 0, 0, 0);
      repeat (3) cycle();
      idle_inputs();
      repeat (2) cycle();
      chk("t4_m0_accesses", n_acc[0], 2);
      chk("t4_release_cycle", hist[3], 0);
      chk("t4_handover", hist[4], 1);

      // Reset lands on an m1 write cycle.
      do_reset();
      set_req(1, 1, 1, 200, 32'h1234);
      cycle();
      r_in = 1'b0;
      cycle();
      r_in = 1'b1;
      idle_inputs();
      cycle();
      chk("t5_idle_after_reset", hist[2], -1);
      set_req(1, 1, 0, 200, 0);
      repeat (2) cycle();
      idle_inputs();
      cycle();
      chk("t5_ram_untouched", ram[200], '0);
      chk("t5_readback", m1_rdata, '0);

`ifdef ADDR_CHECK_EN
      // Out-of-range write then read at DEPTH.
      do_reset();
      set_req(0, 1, 1, DEPTH, 32'h5A);
      repeat (2) cycle();
      set_req(0, 1, 0, DEPTH, 0);
      cycle();
      idle_inputs();
      cycle();
      chk("t6_err_pulses", n_err[0], 2);
      chk("t6_valid_pulses", n_val[0], 1);
`endif

      // Random traffic; requests hold their fields until served.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int m = 0; m < 2; m++) begin
            if (!(q[m] && last_acc != m && $urandom_range(0, 9) != 0)) begin
               q[m] = ($urandom_range(0, 99) < 65);
               w[m] = ($urandom_range(0, 2) == 0);
               a[m] = rand_addr();
               d[m] = $urandom;
            end
         end
         r_in = ($urandom_range(0, 199) != 0);
         cycle();
      end
      r_in = 1'b1;
      idle_inputs();
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
